ts_demux: RTL

TS_DEMUX -- requirements
Module: ts_demux

---
 rtl/ts_demux.sv | 100 ++++++++++
 1 files changed

// File: rtl/ts_demux.sv
// MPEG2-TS packet demultiplexer: locks on SYNC_BYTE and routes whole packets to one of four channels.
// Optional macro TS_DEMUX_DROP_CNT_EN adds a saturating 16-bit drop_cnt output.
//
// Handshake: a transfer happens on any edge where valid && ready are both high.
// A valid never waits on ready. Once valid is raised, data/select hold until that transfer.
module ts_demux #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN = 188,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE = DATA_WIDTH'(8'h47)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            demux_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic                  sync_lost,
  output logic                  locked,
  output logic                  dbg_state
`ifdef TS_DEMUX_DROP_CNT_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PKT_LEN - 1);

  typedef enum logic {HUNT = 1'b0, ROUTE = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] byte_cnt;
  logic [1:0]       pkt_sel;
  logic [1:0]       out_sel;
  logic [1:0]       new_sel;
  logic             out_full;
  logic             accept;
  logic             is_sync;
  logic             at_boundary;
  logic             load;
  logic             drop;

  // A held byte only blocks input if its own channel is stalled.
  assign out_full    = |out_valid;
  assign in_ready    = !out_full || out_ready[out_sel];
  assign accept      = in_valid && in_ready;
  assign is_sync     = (in_data == SYNC_BYTE);
  assign at_boundary = (state == HUNT) || (byte_cnt == '0);
  assign load        = accept && (!at_boundary || is_sync);
  assign drop        = accept && at_boundary && !is_sync;
  assign new_sel     = at_boundary ? demux_ctrl : pkt_sel;
  assign dbg_state   = (state == ROUTE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      byte_cnt  <= '0;
      pkt_sel   <= 2'd0;
      out_sel   <= 2'd0;
      out_valid <= 4'b0000;
      out_data  <= '0;
      sync_lost <= 1'b0;
      locked    <= 1'b0;
    end else begin
      sync_lost <= drop && (state == ROUTE);
      if (load) begin
        out_data  <= in_data;
        out_sel   <= new_sel;
        out_valid <= 4'b0001 << new_sel;
        pkt_sel   <= new_sel;
        byte_cnt  <= (byte_cnt == LAST) ? '0 : byte_cnt + 1'b1;
        state     <= ROUTE;
        locked    <= 1'b1;
      end else begin
        if (out_full && out_ready[out_sel]) begin
          out_valid <= 4'b0000;
        end
        if (drop) begin
          state    <= HUNT;
          locked   <= 1'b0;
          byte_cnt <= '0;
        end
      end
    end
  end

`ifdef TS_DEMUX_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 16'd0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
